// File: rtl/kp_fb_pkg.sv
// Shared definitions for the frame-buffer writer: FSM encoding and frame sizing.
package kp_fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FLIP   = 2'd3
  } fb_state_e;

  function automatic int frame_pixels(input int line_length, input int line_count);
    return line_length * line_count;
  endfunction

endpackage

// File: rtl/kp_fb_addr_gen.sv
// Write-side position tracking: column/row/write counters and the banked write address.
module kp_fb_addr_gen
  import kp_fb_pkg::*;
#(
  parameter int LINE_LENGTH = 480,
  parameter int LINE_COUNT  = 480,
  parameter int ADDR_WIDTH  = 19
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_wr,
  input  logic                  i_bank,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_line_done,
  output logic                  o_last
);

  localparam int FRAME_PIXELS = frame_pixels(LINE_LENGTH, LINE_COUNT);
  localparam int COL_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int ROW_W = $clog2(LINE_COUNT + 1);
  localparam logic [ADDR_WIDTH-1:0] BANK_OFF = ADDR_WIDTH'(FRAME_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LAST_CNT = ADDR_WIDTH'(FRAME_PIXELS - 1);
  localparam logic [COL_W-1:0]      LAST_COL = COL_W'(LINE_LENGTH - 1);

  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic                  line_q, line_d;
  logic                  last_q, last_d;
  logic [ADDR_WIDTH-1:0] base;

  // Bank base is one of two elaboration-time constants; the offset within it is the write count.
  assign base = i_bank ? BANK_OFF : '0;

  always_comb begin
    wcnt_d = wcnt_q;
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    we_d   = 1'b0;
    line_d = 1'b0;
    last_d = 1'b0;
    if (i_clr) begin
      wcnt_d = '0;
      col_d  = '0;
      row_d  = '0;
    end else if (i_wr) begin
      we_d   = 1'b1;
      addr_d = base + wcnt_q;
      wcnt_d = wcnt_q + 1'b1;
      last_d = (wcnt_q == LAST_CNT);
      if (col_q == LAST_COL) begin
        col_d  = '0;
        row_d  = row_q + 1'b1;
        line_d = 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wcnt_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
      we_q   <= 1'b0;
      line_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      col_q  <= col_d;
      row_q  <= row_d;
      addr_q <= addr_d;
      we_q   <= we_d;
      line_q <= line_d;
      last_q <= last_d;
    end
  end

  assign o_we        = we_q;
  assign o_addr      = addr_q;
  assign o_line_done = line_q;
  assign o_last      = last_q;

endmodule

// File: rtl/kp_fb_writer.sv
// Drains a filter output FIFO into a ping-pong frame buffer, flipping banks per frame.
module kp_fb_writer
  import kp_fb_pkg::*;
#(
  parameter int LINE_LENGTH = 480,
  parameter int LINE_COUNT  = 480,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 19
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_start,
  input  logic                  i_continuous,
  input  logic                  i_fb_gnt,
  output logic                  o_obuf_rd,
  input  logic [DATA_WIDTH-1:0] i_obuf_data,
  input  logic                  i_obuf_empty,
  input  logic                  i_obuf_almostempty,
  output logic                  o_fb_we,
  output logic [ADDR_WIDTH-1:0] o_fb_addr,
  output logic [DATA_WIDTH-1:0] o_fb_data,
  output logic                  o_fb_bank,
  output logic                  o_line_done,
  output logic                  o_frame_done,
  output logic                  o_busy
);

  localparam int FRAME_PIXELS = frame_pixels(LINE_LENGTH, LINE_COUNT);
  localparam logic [ADDR_WIDTH-1:0] FP_CNT = ADDR_WIDTH'(FRAME_PIXELS);

  fb_state_e             state_q;
  logic                  obuf_rd_q;
  logic                  rd_d1_q;
  logic [ADDR_WIDTH-1:0] issue_cnt_q;
  logic                  bank_q;
  logic                  frame_done_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  rd_ok;
  logic                  ag_clr;
  logic                  ag_last;

  // While a read is already in flight the FIFO loses a word this edge, so require two words.
  assign rd_ok = i_fb_gnt && (issue_cnt_q < FP_CNT) &&
                 (obuf_rd_q ? !i_obuf_almostempty : !i_obuf_empty);

  assign ag_clr = i_flush || ((state_q == ST_IDLE) && i_start) ||
                  ((state_q == ST_FLIP) && i_continuous);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      obuf_rd_q    <= 1'b0;
      rd_d1_q      <= 1'b0;
      issue_cnt_q  <= '0;
      bank_q       <= 1'b0;
      frame_done_q <= 1'b0;
      data_q       <= '0;
    end else if (i_flush) begin
      state_q      <= ST_IDLE;
      obuf_rd_q    <= 1'b0;
      rd_d1_q      <= 1'b0;
      issue_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      rd_d1_q      <= obuf_rd_q;
      obuf_rd_q    <= 1'b0;
      frame_done_q <= 1'b0;
      if (rd_d1_q) data_q <= i_obuf_data;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q     <= ST_ACTIVE;
            issue_cnt_q <= '0;
          end
        end
        ST_ACTIVE: begin
          if (issue_cnt_q == FP_CNT) begin
            state_q <= ST_DRAIN;
          end else begin
            obuf_rd_q <= rd_ok;
            if (rd_ok) issue_cnt_q <= issue_cnt_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          // ag_last marks the cycle the final pixel of the frame is being written.
          if (ag_last) begin
            state_q      <= ST_FLIP;
            bank_q       <= ~bank_q;
            frame_done_q <= 1'b1;
          end
        end
        ST_FLIP: begin
          issue_cnt_q <= '0;
          state_q     <= i_continuous ? ST_ACTIVE : ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  kp_fb_addr_gen #(
    .LINE_LENGTH (LINE_LENGTH),
    .LINE_COUNT  (LINE_COUNT),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_addr_gen (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (ag_clr),
    .i_wr        (rd_d1_q),
    .i_bank      (bank_q),
    .o_we        (o_fb_we),
    .o_addr      (o_fb_addr),
    .o_line_done (o_line_done),
    .o_last      (ag_last)
  );

  assign o_obuf_rd    = obuf_rd_q;
  assign o_fb_data    = data_q;
  assign o_fb_bank    = bank_q;
  assign o_frame_done = frame_done_q;
  assign o_busy       = (state_q == ST_ACTIVE) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_kp_fb_writer.sv
// Self-checking bench for kp_fb_writer with a 4x2 frame and a 1-cycle-latency FIFO model.
module tb_kp_fb_writer;

  localparam int LL = 4;
  localparam int LC = 2;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1, i_flush = 1'b0, i_start = 1'b0;
  logic          i_continuous = 1'b0, i_fb_gnt = 1'b1;
  logic          o_obuf_rd, o_fb_we, o_fb_bank, o_line_done, o_frame_done, o_busy;
  logic [DW-1:0] i_obuf_data, o_fb_data;
  logic          i_obuf_empty, i_obuf_almostempty;
  logic [AW-1:0] o_fb_addr;

  always #5 clk = ~clk;

  kp_fb_writer #(.LINE_LENGTH(LL), .LINE_COUNT(LC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_start(i_start),
    .i_continuous(i_continuous), .i_fb_gnt(i_fb_gnt), .o_obuf_rd(o_obuf_rd),
    .i_obuf_data(i_obuf_data), .i_obuf_empty(i_obuf_empty),
    .i_obuf_almostempty(i_obuf_almostempty), .o_fb_we(o_fb_we), .o_fb_addr(o_fb_addr),
    .o_fb_data(o_fb_data), .o_fb_bank(o_fb_bank), .o_line_done(o_line_done),
    .o_frame_done(o_frame_done), .o_busy(o_busy)
  );

  int n_vec = 0, n_err = 0;
  int cyc = 0, last_we_cyc = -10;
  int reads_total = 0, pushes_total = 0, wr_seen = 0, fd_cnt = 0, fd_start = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO model: registered read data, flags updated with NBA so the DUT sees pre-edge state.
  logic [DW-1:0] fq[$];
  logic          push_en = 1'b0, fifo_clr = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic [DW-1:0] rdata = '0;
  int            fill = 0;
  assign i_obuf_data        = rdata;
  assign i_obuf_empty       = (fill == 0);
  assign i_obuf_almostempty = (fill <= 1);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_clr) begin
      fq.delete();
    end else begin
      if (o_obuf_rd && fq.size() > 0) rdata <= fq.pop_front();
      if (push_en) fq.push_back(push_data);
    end
    fill <= fq.size();
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          line;
  } wr_t;
  wr_t sb[$];

  always @(negedge clk) begin
    wr_t e;
    if (!i_rst) begin
      if (o_obuf_rd) begin
        reads_total++;
        chk("rd_nonempty", int'(fill != 0), 1);
      end
      if (o_fb_we) begin
        wr_seen++;
        last_we_cyc = cyc;
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL we_expected: got write addr %0d data %h, expected no write", o_fb_addr, o_fb_data);
        end else begin
          e = sb.pop_front();
          chk("we_addr", o_fb_addr, e.addr);
          chk("we_data", o_fb_data, e.data);
          chk("we_line_done", o_line_done, e.line);
          $display("write addr=%0d data=%h line_done=%0b", o_fb_addr, o_fb_data, o_line_done);
        end
      end else if (o_line_done) begin
        chk("line_done_with_we", o_fb_we, 1);
      end
      if (o_frame_done) begin
        fd_cnt++;
        chk("frame_done_lat", cyc - last_we_cyc, 1);
        $display("frame_done bank=%0b", o_fb_bank);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [AW-1:0] a, input bit line, input bit exp_wr);
    push_en = 1'b1;
    push_data = d;
    pushes_total++;
    if (exp_wr) sb.push_back('{a, d, line});
    tick();
    push_en = 1'b0;
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_frame(input bit exp_bank, input bit cont);
    for (int i = 0; i < 300 && fd_cnt == fd_start; i++) tick();
    chk("frame_done_seen", fd_cnt, fd_start + 1);
    chk("bank_after_flip", o_fb_bank, exp_bank);
    chk("sb_drained", sb.size(), 0);
    chk("reads_eq_pushes", reads_total, pushes_total);
    tick();
    chk("busy_after_flip", o_busy, cont);
  endtask

  function automatic logic [DW-1:0] pix(input int f, input int i);
    return DW'(f * 256 + i + 1);
  endfunction

  typedef struct {
    bit            need_start;
    bit            cont;
    int            gap;
    logic [AW-1:0] exp_base;
    bit            exp_bank;
  } vec_t;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   f;
    int   wr0;
    int   rd0;
    vecs[0] = '{1'b1, 1'b0, 0, 4'd0, 1'b1};  // single frame into bank 0
    vecs[1] = '{1'b1, 1'b1, 0, 4'd8, 1'b0};  // continuous into bank 1
    vecs[2] = '{1'b0, 1'b0, 0, 4'd0, 1'b1};  // auto re-armed frame back in bank 0
    vecs[3] = '{1'b1, 1'b0, 2, 4'd8, 1'b0};  // one word every 3 cycles
    f = 0;

    repeat (3) tick();
    i_rst = 1'b0;
    tick();
    chk("rst_we", o_fb_we, 0);
    chk("rst_rd", o_obuf_rd, 0);
    chk("rst_bank", o_fb_bank, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_frame_done", o_frame_done, 0);
    chk("rst_line_done", o_line_done, 0);
    chk("rst_addr", o_fb_addr, 0);

    for (int v = 0; v < 4; v++) begin
      $display("vector %0d: start=%0b cont=%0b gap=%0d base=%0d", v, vecs[v].need_start,
               vecs[v].cont, vecs[v].gap, vecs[v].exp_base);
      fd_start = fd_cnt;
      i_continuous = vecs[v].cont;
      if (vecs[v].need_start) start_pulse();
      for (int i = 0; i < LL * LC; i++) begin
        push(pix(f, i), vecs[v].exp_base + AW'(i), (i % LL) == LL - 1, 1'b1);
        repeat (vecs[v].gap) tick();
      end
      wait_frame(vecs[v].exp_bank, vecs[v].cont);
      f++;
    end

    // Grant withdrawn after two reads: both in-flight words still land, nothing new is read.
    $display("sequence: grant drop");
    fd_start = fd_cnt;
    i_fb_gnt = 1'b0;
    for (int i = 0; i < LL * LC; i++) push(pix(f, i), AW'(i), (i % LL) == LL - 1, 1'b1);
    start_pulse();
    rd0 = reads_total;
    i_fb_gnt = 1'b1;
    for (int i = 0; i < 50 && reads_total < rd0 + 2; i++) tick();
    chk("two_reads_seen", reads_total - rd0, 2);
    i_fb_gnt = 1'b0;
    wr0 = wr_seen;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("no_rd_without_gnt", o_obuf_rd, 0);
    end
    chk("inflight_written", wr_seen - wr0, 2);
    i_fb_gnt = 1'b1;
    wait_frame(1'b1, 1'b0);
    f++;

    // Flush after five writes: in-flight words dropped, bank kept, no frame_done.
    $display("sequence: flush");
    fd_start = fd_cnt;
    wr0 = wr_seen;
    for (int i = 0; i < LL * LC; i++) push(pix(f, i), AW'(8 + i), (i % LL) == LL - 1, i < 5);
    start_pulse();
    for (int i = 0; i < 100 && wr_seen < wr0 + 5; i++) tick();
    chk("five_writes", wr_seen - wr0, 5);
    i_flush = 1'b1;
    fifo_clr = 1'b1;
    tick();
    i_flush = 1'b0;
    fifo_clr = 1'b0;
    chk("flush_we_low", o_fb_we, 0);
    chk("flush_idle", o_busy, 0);
    chk("flush_bank_kept", o_fb_bank, 1);
    repeat (5) tick();
    chk("flush_no_frame_done", fd_cnt, fd_start);
    chk("flush_writes_stopped", wr_seen - wr0, 5);
    pushes_total = reads_total;
    f++;

    // Restart after flush begins at the bank base; a mid-frame start pulse is ignored.
    $display("sequence: restart after flush");
    fd_start = fd_cnt;
    start_pulse();
    for (int i = 0; i < LL * LC; i++) begin
      push(pix(f, i), AW'(8 + i), (i % LL) == LL - 1, 1'b1);
      if (i == 4) start_pulse();
    end
    wait_frame(1'b0, 1'b0);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
